// File: rtl/fixed_point_mul_pipe_if.sv
// Operand/result stream bundle for fixed_point_mul_pipe.
//   in_*  : operand beat (valid/ready, two signed operands, per-beat round/sat mode)
//   out_* : result beat (valid/ready, signed fixed-point product, overflow flag)
// master = producer of operands / consumer of results; slave = the multiplier.
interface fixed_point_mul_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic             in_round;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_ovf;

  modport master (
    output in_valid, in_op1, in_op2, in_round, in_sat, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_round, in_sat, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/fixed_point_mul_pipe.sv
// Pipelined signed fixed-point multiplier, Q(WIDTH-FRAC_W).FRAC_W operands and result.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : operand/result streams (slave side), full backpressure
//   ovf_clear  : zero the overflow event counter (wins over a same-cycle increment)
//   ovf_count  : saturating count of overflowed results handed downstream
// All stages shift together when the output register is empty or being drained.
module fixed_point_mul_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fixed_point_mul_pipe_if.slave bus,
  input  logic                  ovf_clear,
  output logic [CNT_W-1:0]      ovf_count
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned HW   = WIDTH / 2;
  localparam int unsigned HI_W = WIDTH - HW;
  localparam int unsigned TW   = PW - WIDTH + 2;

  function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  logic                 advance_c;
  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [LATENCY-2:0]   rnd_q, rnd_d, sat_q, sat_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [PW:0]          rnd_add_c, sum_c, q_c;
  logic [TW-1:0]        top_c;
  logic                 ovf_c;
  logic [WIDTH-1:0]     res_c;

  // Product register sits at stage LATENCY-1; earlier stages depend on depth.
  if (LATENCY == 2) begin : g_lat2
    always_comb begin
      prod_d = prod_q;
      if (advance_c) prod_d = sext(bus.in_op1) * sext(bus.in_op2);
    end
  end else begin : g_lat_ge3
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;

    always_comb begin
      op1_d = op1_q;
      op2_d = op2_q;
      if (advance_c) begin
        op1_d = bus.in_op1;
        op2_d = bus.in_op2;
      end
    end

    always_ff @(posedge clk) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
    end

    if (LATENCY == 3) begin : g_lat3
      always_comb begin
        prod_d = prod_q;
        if (advance_c) prod_d = sext(op1_q) * sext(op2_q);
      end
    end else begin : g_lat4
      // op2 = hi*2^HW + lo with hi signed, lo unsigned; partials summed next stage.
      logic [PW-1:0] pp_lo_q, pp_lo_d, pp_hi_q, pp_hi_d;

      always_comb begin
        pp_lo_d = pp_lo_q;
        pp_hi_d = pp_hi_q;
        prod_d  = prod_q;
        if (advance_c) begin
          pp_lo_d = sext(op1_q) * {{(PW-HW){1'b0}}, op2_q[HW-1:0]};
          pp_hi_d = sext(op1_q) * {{(PW-HI_W){op2_q[WIDTH-1]}}, op2_q[WIDTH-1:HW]};
          prod_d  = (pp_hi_q << HW) + pp_lo_q;
        end
      end

      always_ff @(posedge clk) begin
        pp_lo_q <= pp_lo_d;
        pp_hi_q <= pp_hi_d;
      end
    end
  end

  // Round/shift on a one-bit-wider sum so the half-LSB add can never wrap.
  always_comb begin
    rnd_add_c = '0;
    if (rnd_q[LATENCY-2]) rnd_add_c = (PW+1)'(1) << (FRAC_W - 1);
    sum_c = {prod_q[PW-1], prod_q} + rnd_add_c;
    q_c   = (PW+1)'($signed(sum_c) >>> FRAC_W);
    top_c = q_c[PW:WIDTH-1];
    ovf_c = (top_c != '0) && (top_c != '1);
    res_c = q_c[WIDTH-1:0];
    if (ovf_c && sat_q[LATENCY-2]) begin
      res_c = q_c[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Stage valids, mode bits and output register advance in lockstep.
  always_comb begin
    advance_c = !vld_q[LATENCY-1] || bus.out_ready;
    vld_d     = vld_q;
    rnd_d     = rnd_q;
    sat_d     = sat_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    if (advance_c) begin
      vld_d[0] = bus.in_valid;
      rnd_d[0] = bus.in_round;
      sat_d[0] = bus.in_sat;
      for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
      for (int i = 1; i < LATENCY - 1; i++) begin
        rnd_d[i] = rnd_q[i-1];
        sat_d[i] = sat_q[i-1];
      end
      result_d = res_c;
      ovf_d    = ovf_c;
    end
  end

  // Saturating overflow counter; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clear) begin
      cnt_d = '0;
    end else if (vld_q[LATENCY-1] && bus.out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath payload needs no reset: it is qualified by the stage valids.
  always_ff @(posedge clk) begin
    rnd_q  <= rnd_d;
    sat_q  <= sat_d;
    prod_q <= prod_d;
  end

  assign bus.in_ready   = advance_c;
  assign bus.out_valid  = vld_q[LATENCY-1];
  assign bus.out_result = result_q;
  assign bus.out_ovf    = ovf_q;
  assign ovf_count      = cnt_q;

endmodule
